mult_job_scheduler: RTL and testbench

//  Shares one approximate-multiplier core among NREQ requesters. Captures one operand pair
//  per job, pulses the core's start, waits for its done, and returns the product tagged

---
 rtl/mult_job_scheduler_if.sv | 27 ++
 rtl/mult_job_scheduler.sv | 171 +++++++++++++++++
 tb/tb_mult_job_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_job_scheduler_if.sv
// Requester-side bundle for mult_job_scheduler.
//   master: requesters  (drive req_valid/req_a/req_b, observe req_ready and rsp_*)
//   slave : scheduler   (observe req_*, drive req_ready and rsp_*)
interface mult_job_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [2*DW-1:0]    rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/mult_job_scheduler.sv
// Round-robin scheduler sharing one multiplier core among NREQ requesters.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : requester jobs in, one-hot req_ready, tagged response out
//   core_*      : start/operands to the core, done/result back
// Optional: SCHED_TIMEOUT_EN adds a WAIT timeout that returns rsp_err=1, rsp_data=0.
module mult_job_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_job_scheduler_if.slave  bus,
  output logic                 core_start,
  output logic [DW-1:0]        core_a,
  output logic [DW-1:0]        core_b,
  input  logic                 core_done,
  input  logic [2*DW-1:0]      core_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            core_start_q, core_start_d;
  logic [DW-1:0]   core_a_q, core_a_d;
  logic [DW-1:0]   core_b_q, core_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [2*DW-1:0] rsp_data_q, rsp_data_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  logic [IDW-1:0] win;
  logic           win_found;
  int unsigned    idx;

  // First requesting index at or after ptr, wrapping at NREQ-1.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && bus.req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win       = IDW'(idx);
      end
    end
  end

  // Outputs are registered: each one is set on the edge that enters its state.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    req_ready_d  = '0;
    core_start_d = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d             = win;
          core_a_d         = bus.req_a[32'(win)*DW +: DW];
          core_b_d         = bus.req_b[32'(win)*DW +: DW];
          req_ready_d[win] = 1'b1;
          core_start_d     = 1'b1;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          rsp_data_d  = core_result;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
`ifdef SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end
`ifdef SCHED_TIMEOUT_EN
        // Compare before increment so RESP lands TIMEOUT+1 cycles after ISSUE.
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      req_ready_q  <= '0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
`ifdef SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      req_ready_q  <= req_ready_d;
      core_start_q <= core_start_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign core_start    = core_start_q;
  assign core_a        = core_a_q;
  assign core_b        = core_b_q;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Bench for mult_job_scheduler: per-requester job queues, behavioural core,
// grant/response scoreboard.
module tb_mult_job_scheduler;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_start;
  logic [15:0] core_a, core_b;
  logic        core_done;
  logic [31:0] core_result;

  always #5 clk = ~clk;

  mult_job_scheduler_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  mult_job_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .core_start  (core_start),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_done   (core_done),
    .core_result (core_result)
  );

  typedef struct {logic [15:0] a; logic [15:0] b;} job_t;
  typedef struct {int id; logic [15:0] a; logic [15:0] b;} grant_t;
  typedef struct {int id; logic [31:0] data; logic err;} rsp_t;

  job_t   jobs[NREQ][$];
  grant_t exp_grant[$];
  rsp_t   exp_rsp[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_req = 0, t_start = 0, t_done = 0, t_rsp = 0;
  int rsp_count = 0;
  int core_lat  = 0;
  bit core_auto = 1'b1;
  bit inject_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_job(input int id, input logic [15:0] a, input logic [15:0] b, input bit want_rsp);
    job_t j; grant_t g; rsp_t r;
    j.a = a; j.b = b;
    jobs[id].push_back(j);
    g.id = id; g.a = a; g.b = b;
    exp_grant.push_back(g);
    if (want_rsp) begin
      r.id = id; r.data = 32'(a) * 32'(b); r.err = 1'b0;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < NREQ; i++) jobs[i].delete();
    exp_grant.delete();
    exp_rsp.delete();
    inject_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_drain"}, 64'(exp_grant.size() + exp_rsp.size()), 64'd0);
    exp_grant.delete();
    exp_rsp.delete();
  endtask

  task automatic check_zero_outputs(input string p);
    check_value({p, "_req_ready"},  64'(bus.req_ready),  64'd0);
    check_value({p, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
    check_value({p, "_rsp_id"},     64'(bus.rsp_id),     64'd0);
    check_value({p, "_rsp_data"},   64'(bus.rsp_data),   64'd0);
    check_value({p, "_rsp_err"},    64'(bus.rsp_err),    64'd0);
    check_value({p, "_core_start"}, 64'(core_start),     64'd0);
    check_value({p, "_core_a"},     64'(core_a),         64'd0);
    check_value({p, "_core_b"},     64'(core_b),         64'd0);
  endtask

  // Requesters: hold the head job valid until its req_ready is seen.
  initial begin
    logic [NREQ-1:0]    v;
    logic [NREQ*DW-1:0] va, vb;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    forever begin
      @(negedge clk);
      v = '0; va = '0; vb = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst && bus.req_ready[i] && jobs[i].size() > 0) void'(jobs[i].pop_front());
        if (jobs[i].size() > 0) begin
          v[i] = 1'b1;
          va[i*DW +: DW] = jobs[i][0].a;
          vb[i*DW +: DW] = jobs[i][0].b;
        end
      end
      if (v != '0 && bus.req_valid == '0) t_req = cyc;
      bus.req_valid = v;
      bus.req_a     = va;
      bus.req_b     = vb;
    end
  end

  // Behavioural core: answers a*b after core_lat cycles (random 2..9 when 0).
  initial begin
    bit          busy = 1'b0;
    int          cnt  = 0;
    logic [31:0] prod = '0;
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (inject_done) begin
          core_done   = 1'b1;
          core_result = 32'hDEAD_BEEF;
          inject_done = 1'b0;
          t_done      = cyc;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            core_done   = 1'b1;
            core_result = prod;
            busy        = 1'b0;
            t_done      = cyc;
          end
        end
        if (core_start && core_auto) begin
          busy = 1'b1;
          cnt  = (core_lat != 0) ? core_lat : int'($urandom_range(9, 2));
          prod = 32'(core_a) * 32'(core_b);
        end
      end
    end
  end

  // Monitor: grants and responses against the scoreboard.
  initial begin
    grant_t g;
    rsp_t   r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.req_ready != '0) begin
          if (exp_grant.size() == 0) begin
            check_value("grant_unexp", 64'(bus.req_ready), 64'd0);
          end else begin
            g = exp_grant.pop_front();
            check_value("grant_id", 64'(bus.req_ready), 64'd1 << g.id);
            check_value("start_with_ready", 64'(core_start), 64'd1);
            check_value("core_a", 64'(core_a), 64'(g.a));
            check_value("core_b", 64'(core_b), 64'(g.b));
          end
        end
        if (core_start) begin
          t_start = cyc;
          check_value("ready_with_start", 64'(|bus.req_ready), 64'd1);
        end
        if (bus.rsp_valid) begin
          rsp_count++;
          t_rsp = cyc;
          if (exp_rsp.size() == 0) begin
            check_value("rsp_unexp", 64'(bus.rsp_valid), 64'd0);
          end else begin
            r = exp_rsp.pop_front();
            check_value("rsp_id",   64'(bus.rsp_id),   64'(r.id));
            check_value("rsp_data", 64'(bus.rsp_data), 64'(r.data));
            check_value("rsp_err",  64'(bus.rsp_err),  64'(r.err));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t2a[4] = '{16'h0003, 16'hFFFF, 16'h8001, 16'h0100};
    logic [15:0] t2b[4] = '{16'h0005, 16'hFFFF, 16'h0002, 16'h0FF0};
    int rc;
`ifdef SCHED_TIMEOUT_EN
    rsp_t to;
`endif

    do_reset();
    @(negedge clk);
    check_zero_outputs("reset");

    // Single job, core latency 20.
    @(posedge clk); #1;
    core_lat = 20;
    add_job(0, 16'h00F3, 16'h0012, 1'b1);
    wait_drain(100, "t1");
    check_value("t1_start_lat", 64'(t_start - t_req), 64'd1);
    check_value("t1_rsp_lat",   64'(t_rsp - t_done),  64'd1);
    repeat (3) @(negedge clk);
    check_value("t1_data_hold", 64'(bus.rsp_data), 64'h0000_1116);

    // All four requesting at once: grants 0,1,2,3.
    do_reset();
    core_lat = 0;
    for (int i = 0; i < 4; i++) add_job(i, t2a[i], t2b[i], 1'b1);
    wait_drain(400, "t2");

    // Requesters 0 and 3 held high: grants alternate 0,3,0,3,0,3.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_job(0, 16'h0101 + 16'(k), 16'h0020 + 16'(k), 1'b1);
      add_job(3, 16'hF000 + 16'(k), 16'h0003 + 16'(k), 1'b1);
    end
    wait_drain(400, "t3");

    // Reset in WAIT, stray core_done two cycles after reset release.
    do_reset();
    core_auto = 1'b0;
    add_job(1, 16'h0042, 16'h0007, 1'b0);
    wait_drain(50, "t4_grant");
    repeat (5) @(posedge clk);
    rc = rsp_count;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    inject_done = 1'b1;
    @(negedge clk);
    check_zero_outputs("t4");
    repeat (20) @(negedge clk);
    check_value("t4_no_rsp", 64'(rsp_count), 64'(rc));
    core_auto = 1'b1;
    @(posedge clk); #1;
    add_job(2, 16'h1001, 16'h0010, 1'b1);
    wait_drain(100, "t4_next");
    check_value("t4_idle_accept", 64'(t_start - t_req), 64'd1);

    // core_done while IDLE is ignored; response registers hold.
    @(posedge clk); #1;
    rc = rsp_count;
    inject_done = 1'b1;
    repeat (6) @(negedge clk);
    check_value("t6_no_rsp",    64'(rsp_count),    64'(rc));
    check_value("t6_data_hold", 64'(bus.rsp_data), 64'h0001_0010);
    check_value("t6_id_hold",   64'(bus.rsp_id),   64'd2);

    // Core that never completes.
    do_reset();
    core_auto = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    add_job(0, 16'h00AA, 16'h0055, 1'b0);
    to.id = 0; to.data = '0; to.err = 1'b1;
    exp_rsp.push_back(to);
    wait_drain(100, "t5");
    check_value("t5_timeout_lat", 64'(t_rsp - t_start), 64'd16);
`else
    add_job(0, 16'h00AA, 16'h0055, 1'b0);
    wait_drain(50, "t5_grant");
    rc = rsp_count;
    repeat (1000) @(negedge clk);
    check_value("t5_no_rsp", 64'(rsp_count), 64'(rc));
    check_value("t5_err",    64'(bus.rsp_err), 64'd0);
`endif
    do_reset();
    core_auto = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
